gpmc_sram_bridge: RTL and testbench
===================================

Name: gpmc_sram_bridge

Overview:
- Parametrised GPMC-to-block-RAM bridge for the FPGA side of the OMAP GPMC bus, replacing the fixed 11-bit single-beat controller.
- Latches the address on ADV and runs single or burst read/write beats with auto-increment.
- Supports byte-lane writes and a configurable RAM read latency, and flags protocol errors.
- Sits between the GPMC pins (tristate handled at top level) and one port of a dual-port SRAM.

Parameters:
ADDR_W, 11, RAM word-address width (1..16); taken from GPMC_AD_IN[ADDR_W-1:0]
RD_LAT, 1, RAM read latency in cycles from a_ena to a_dout valid (1..4)

Ports:
GPMC_CLK  in  1  bus clock; all logic on rising edge
GPMC_RST  in  1  synchronous, active-high reset
GPMC_AD_IN  in  16  multiplexed address/data from pins
GPMC_DATA_OUT  out  16  read data to pins
GPMC_DATA_OE  out  1  high = FPGA drives AD bus
GPMC_WAIT  out  1  high = read data not yet valid
GPMC_CS  in  1  chip select, active-low
GPMC_ADV  in  1  address valid, active-low
GPMC_OE  in  1  output enable (read), active-low
GPMC_WE  in  1  write enable, active-low
GPMC_BE0  in  1  low-byte enable, active-low
GPMC_BE1  in  1  high-byte enable, active-low
err  out  1  sticky protocol-error flag
a_ena  out  1  RAM enable
a_wr  out  2  RAM byte write enables [1]=high byte
a_addr  out  ADDR_W  RAM address
a_din  out  16  RAM write data
a_dout  in  16  RAM read data

Behaviour:
- Reset: state IDLE; a_ena=0, a_wr=0, a_addr=0, a_din=0, GPMC_DATA_OUT=0, GPMC_DATA_OE=0, GPMC_WAIT=0, err=0, read pipeline valid bits cleared.
- States: IDLE, ACTIVE, READ, WRITE.
- IDLE: on an edge with CS=0 and ADV=0, latch a_addr=AD_IN[ADDR_W-1:0] and go to ACTIVE. No RAM access on the address cycle.
- ACTIVE/READ/WRITE, per edge with CS=0:
  - ADV=0: re-latch address, go to ACTIVE, no access that cycle.
  - WE=0, OE=1: write beat. a_ena=1, a_wr={~BE1,~BE0}, a_din=AD_IN at the current address. Address increments after the beat. State WRITE.
  - OE=0, WE=1: read beat. a_ena=1, a_wr=0. Address increments after the beat. State READ.
  - WE=0 and OE=0: no access; set err; state unchanged.
  - Neither low: a_ena=0, a_wr=0, hold address.
- Read pipeline: a_dout is registered into GPMC_DATA_OUT exactly RD_LAT+1 cycles after the issuing beat. Beats pipeline at one per cycle.
- GPMC_DATA_OE is high while in READ or while any read is in flight; it is low otherwise, including during writes.
- Address wraps from 2^ADDR_W-1 to 0 with no error.
- CS high on any edge: go to IDLE; a_ena=0, a_wr=0; in-flight reads flushed; GPMC_DATA_OE=0 next cycle; GPMC_DATA_OUT holds.
- err clears only on GPMC_RST.
- GPMC_RST mid-burst: reset values next edge; it overrides all bus inputs.

Optional Feature:
- GPMC_WAIT_EN defined: GPMC_WAIT rises on the first read beat after an address latch. It falls on the cycle GPMC_DATA_OUT first holds that beat's data (RD_LAT+1 cycles). It does not reassert within the same burst.
- GPMC_WAIT_EN undefined: GPMC_WAIT tied 0. The port is still present.

Decomposition:
- Package gpmc_pkg: state enum, GPMC_AD_W=16, RD_LAT_MAX=4.
- Sub-module gpmc_rd_pipe: RD_LAT-deep valid shift register with flush input. It drives the data-capture enable and the in-flight indicator.

Test Plan:
- ADDR 0x012, single write 0xBEEF with both BEs low -> a_addr=0x012, a_wr=2'b11, a_din=0xBEEF for one cycle.
- Burst read of 4 from 0x100, RAM holding addr+0x1000 -> GPMC_DATA_OUT = 0x1100..0x1103 on consecutive cycles, starting RD_LAT+1 cycles after the first beat.
- Write with BE1=1, BE0=0 at 0x7FF (ADDR_W=11), then a second beat -> a_wr=2'b01 at 0x7FF, next beat at 0x000.
- CS deasserted after 2 of 4 read beats -> a_ena=0 next edge; GPMC_DATA_OE=0 next cycle; no further DATA_OUT updates.
- WE and OE both low -> no RAM access; err=1 and stays 1 until GPMC_RST.
- With GPMC_WAIT_EN and RD_LAT=3 -> GPMC_WAIT high for 4 cycles from the first read beat.

Source files
------------

// File: rtl/gpmc_pkg.sv
// Shared types and constants for the GPMC-to-SRAM bridge.
package gpmc_pkg;

  localparam int GPMC_AD_W  = 16;
  localparam int RD_LAT_MAX = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_READ,
    ST_WRITE
  } gpmc_state_e;

endpackage

// File: rtl/gpmc_rd_pipe.sv
// Read-beat valid pipeline: tracks beats until their RAM data can be captured.
// A flush drops every in-flight beat and suppresses capture on that same edge.
module gpmc_rd_pipe
  import gpmc_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic GPMC_CLK,
  input  logic GPMC_RST,
  input  logic issue,
  input  logic flush,
  output logic capture,
  output logic in_flight
);

  localparam int DEPTH = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : ((RD_LAT < 1) ? 1 : RD_LAT);

  logic [DEPTH-1:0] vld;

  always_ff @(posedge GPMC_CLK) begin
    if (GPMC_RST || flush) begin
      vld <= '0;
    end else begin
      vld[0] <= issue;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  assign capture   = vld[DEPTH-1] & ~flush;
  assign in_flight = issue | (|vld);

endmodule

// File: rtl/gpmc_sram_bridge.sv
// GPMC bus to single-port view of a block RAM: address latch, burst beats, byte lanes.
// Define GPMC_WAIT_EN to drive GPMC_WAIT during the first read of a burst.
module gpmc_sram_bridge
  import gpmc_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int RD_LAT = 1
) (
  input  logic                 GPMC_CLK,
  input  logic                 GPMC_RST,
  input  logic [GPMC_AD_W-1:0] GPMC_AD_IN,
  output logic [GPMC_AD_W-1:0] GPMC_DATA_OUT,
  output logic                 GPMC_DATA_OE,
  output logic                 GPMC_WAIT,
  input  logic                 GPMC_CS,
  input  logic                 GPMC_ADV,
  input  logic                 GPMC_OE,
  input  logic                 GPMC_WE,
  input  logic                 GPMC_BE0,
  input  logic                 GPMC_BE1,
  output logic                 err,
  output logic                 a_ena,
  output logic [1:0]           a_wr,
  output logic [ADDR_W-1:0]    a_addr,
  output logic [GPMC_AD_W-1:0] a_din,
  input  logic [GPMC_AD_W-1:0] a_dout
);

  // state     | meaning
  // ST_IDLE   | not selected, waiting for CS+ADV address cycle
  // ST_ACTIVE | address latched, no beat yet
  // ST_READ   | last beat was a read, bus driven by FPGA
  // ST_WRITE  | last beat was a write

  gpmc_state_e state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d, ptr_q, ptr_d;
  logic                 ena_q, ena_d;
  logic [1:0]           wr_q, wr_d;
  logic [GPMC_AD_W-1:0] din_q, din_d, dout_q;
  logic                 err_q, err_d;
  logic                 rd_beat, rd_iss_q, flush, capture, in_flight;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ptr_d   = ptr_q;
    ena_d   = 1'b0;
    wr_d    = 2'b00;
    din_d   = din_q;
    err_d   = err_q;
    flush   = 1'b0;
    rd_beat = 1'b0;
    if (GPMC_CS) begin
      state_d = ST_IDLE;
      flush   = 1'b1;
    end else if (!GPMC_ADV) begin
      state_d = ST_ACTIVE;
      addr_d  = GPMC_AD_IN[ADDR_W-1:0];
      ptr_d   = GPMC_AD_IN[ADDR_W-1:0];
    end else if (state_q != ST_IDLE) begin
      // ptr_q is the next beat address; a_addr shows the beat in progress
      case ({GPMC_WE, GPMC_OE})
        2'b01: begin
          state_d = ST_WRITE;
          ena_d   = 1'b1;
          wr_d    = {~GPMC_BE1, ~GPMC_BE0};
          din_d   = GPMC_AD_IN;
          addr_d  = ptr_q;
          ptr_d   = ptr_q + 1'b1;
        end
        2'b10: begin
          state_d = ST_READ;
          ena_d   = 1'b1;
          rd_beat = 1'b1;
          addr_d  = ptr_q;
          ptr_d   = ptr_q + 1'b1;
        end
        2'b00:   err_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge GPMC_CLK) begin
    if (GPMC_RST) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      ptr_q    <= '0;
      ena_q    <= 1'b0;
      wr_q     <= 2'b00;
      din_q    <= '0;
      dout_q   <= '0;
      err_q    <= 1'b0;
      rd_iss_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      ptr_q    <= ptr_d;
      ena_q    <= ena_d;
      wr_q     <= wr_d;
      din_q    <= din_d;
      err_q    <= err_d;
      rd_iss_q <= rd_beat;
      if (capture) dout_q <= a_dout;
    end
  end

  gpmc_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
    .GPMC_CLK  (GPMC_CLK),
    .GPMC_RST  (GPMC_RST),
    .issue     (rd_iss_q),
    .flush     (flush),
    .capture   (capture),
    .in_flight (in_flight)
  );

`ifdef GPMC_WAIT_EN
  localparam int WCNT_W = $clog2(RD_LAT_MAX + 2);
  localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(RD_LAT + 1);

  logic              first_q;
  logic [WCNT_W-1:0] wcnt_q;

  // Down-counter spans issue through the edge that captures the first beat
  always_ff @(posedge GPMC_CLK) begin
    if (GPMC_RST || GPMC_CS) begin
      first_q <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      if (!GPMC_ADV) first_q <= 1'b1;
      else if (rd_beat) first_q <= 1'b0;
      if (rd_beat && first_q) wcnt_q <= WAIT_LOAD;
      else if (wcnt_q != '0) wcnt_q <= wcnt_q - 1'b1;
    end
  end

  assign GPMC_WAIT = (wcnt_q != '0);
`else
  assign GPMC_WAIT = 1'b0;
`endif

  assign a_ena         = ena_q;
  assign a_wr          = wr_q;
  assign a_addr        = addr_q;
  assign a_din         = din_q;
  assign err           = err_q;
  assign GPMC_DATA_OUT = dout_q;
  assign GPMC_DATA_OE  = (state_q == ST_READ) | in_flight;

endmodule

// File: tb/tb_gpmc_sram_bridge.sv
// Self-checking bench: behavioural RAM, transaction-level bridge model, directed + random traffic.
module tb_gpmc_sram_bridge;

  localparam int ADDR_W = 11;
`ifdef GPMC_WAIT_EN
  localparam int RD_LAT = 3;
`else
  localparam int RD_LAT = 2;
`endif
  localparam int DEPTH = 1 << ADDR_W;
  localparam int MASK  = DEPTH - 1;

  logic              GPMC_CLK = 1'b0;
  logic              GPMC_RST = 1'b1;
  logic [15:0]       GPMC_AD_IN = '0;
  logic              GPMC_CS = 1'b1, GPMC_ADV = 1'b1, GPMC_OE = 1'b1, GPMC_WE = 1'b1;
  logic              GPMC_BE0 = 1'b1, GPMC_BE1 = 1'b1;
  logic [15:0]       GPMC_DATA_OUT;
  logic              GPMC_DATA_OE, GPMC_WAIT, err, a_ena;
  logic [1:0]        a_wr;
  logic [ADDR_W-1:0] a_addr;
  logic [15:0]       a_din, a_dout;

  gpmc_sram_bridge #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .GPMC_CLK(GPMC_CLK), .GPMC_RST(GPMC_RST), .GPMC_AD_IN(GPMC_AD_IN),
    .GPMC_DATA_OUT(GPMC_DATA_OUT), .GPMC_DATA_OE(GPMC_DATA_OE), .GPMC_WAIT(GPMC_WAIT),
    .GPMC_CS(GPMC_CS), .GPMC_ADV(GPMC_ADV), .GPMC_OE(GPMC_OE), .GPMC_WE(GPMC_WE),
    .GPMC_BE0(GPMC_BE0), .GPMC_BE1(GPMC_BE1), .err(err), .a_ena(a_ena), .a_wr(a_wr),
    .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout)
  );

  always #5 GPMC_CLK = ~GPMC_CLK;

  // Behavioural RAM with RD_LAT-cycle read latency
  logic [15:0] ram [DEPTH];
  logic [15:0] stg [RD_LAT];
  always @(posedge GPMC_CLK) begin
    if (a_ena && a_wr[0]) ram[a_addr][7:0]  <= a_din[7:0];
    if (a_ena && a_wr[1]) ram[a_addr][15:8] <= a_din[15:8];
    stg[0] <= ram[a_addr];
    for (int i = 1; i < RD_LAT; i++) stg[i] <= stg[i-1];
  end
  assign a_dout = stg[RD_LAT-1];

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model of the bridge
  typedef struct {
    int          due;
    logic [15:0] data;
  } rd_t;

  rd_t         q[$];
  rd_t         ent;
  logic [15:0] ref_mem [DEPTH];
  int          cyc = 0;
  bit          m_bound = 0, m_read = 0, m_ena = 0, m_wbeat = 0, m_err = 0, m_first = 0;
  logic [1:0]  m_wr = 0;
  int          m_addr = 0, m_ptr = 0, m_wait_end = 0;
  logic [15:0] m_din = 0, m_dout = 0;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = 16'(16'h1000 + i);
      ref_mem[i] = 16'(16'h1000 + i);
    end
  end

  always @(posedge GPMC_CLK) begin
    cyc++;
    m_ena = 0; m_wr = 0; m_wbeat = 0;
    if (GPMC_RST) begin
      m_bound = 0; m_read = 0; m_addr = 0; m_ptr = 0; m_din = 0; m_dout = 0;
      m_err = 0; m_first = 0; m_wait_end = 0; q.delete();
    end else if (GPMC_CS) begin
      m_bound = 0; m_read = 0; m_first = 0; m_wait_end = 0; q.delete();
    end else if (!GPMC_ADV) begin
      m_bound = 1; m_read = 0; m_first = 1;
      m_addr = int'(GPMC_AD_IN) & MASK; m_ptr = m_addr;
    end else if (m_bound) begin
      if (!GPMC_WE && GPMC_OE) begin
        m_ena = 1; m_wbeat = 1; m_wr = {!GPMC_BE1, !GPMC_BE0};
        m_din = GPMC_AD_IN; m_addr = m_ptr;
        if (!GPMC_BE0) ref_mem[m_ptr][7:0]  = GPMC_AD_IN[7:0];
        if (!GPMC_BE1) ref_mem[m_ptr][15:8] = GPMC_AD_IN[15:8];
        m_ptr = (m_ptr + 1) & MASK; m_read = 0;
      end else if (!GPMC_OE && GPMC_WE) begin
        m_ena = 1; m_addr = m_ptr;
        ent.due = cyc + RD_LAT + 1; ent.data = ref_mem[m_ptr];
        q.push_back(ent);
        if (m_first) m_wait_end = cyc + RD_LAT + 1;
        m_first = 0;
        m_ptr = (m_ptr + 1) & MASK; m_read = 1;
      end else if (!GPMC_OE && !GPMC_WE) begin
        m_err = 1;
      end
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      m_dout = q[0].data;
      void'(q.pop_front());
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge GPMC_CLK) begin
    if (chk_en) begin
      chk("a_ena", 32'(a_ena), 32'(m_ena));
      chk("a_wr", 32'(a_wr), 32'(m_wr));
      chk("a_addr", 32'(a_addr), 32'(m_addr));
      if (m_wbeat) chk("a_din", 32'(a_din), 32'(m_din));
      chk("data_out", 32'(GPMC_DATA_OUT), 32'(m_dout));
      chk("data_oe", 32'(GPMC_DATA_OE), 32'(m_read || q.size() != 0));
`ifdef GPMC_WAIT_EN
      chk("wait", 32'(GPMC_WAIT), 32'(cyc < m_wait_end));
`else
      chk("wait", 32'(GPMC_WAIT), 32'd0);
`endif
      chk("err", 32'(err), 32'(m_err));
    end
  end

  task automatic bus(input bit cs, input bit adv, input bit we, input bit oe,
                     input logic [1:0] be_n, input logic [15:0] ad);
    GPMC_CS = cs; GPMC_ADV = adv; GPMC_WE = we; GPMC_OE = oe;
    GPMC_BE1 = be_n[1]; GPMC_BE0 = be_n[0]; GPMC_AD_IN = ad;
    @(posedge GPMC_CLK);
    #1;
  endtask

  initial begin
    int r;
    bus(1, 1, 1, 1, 2'b11, 16'h0);
    chk_en = 1'b1;
    bus(1, 1, 1, 1, 2'b11, 16'h0);
    chk("rst_a_ena", 32'(a_ena), 0);
    chk("rst_a_wr", 32'(a_wr), 0);
    chk("rst_a_addr", 32'(a_addr), 0);
    chk("rst_a_din", 32'(a_din), 0);
    chk("rst_dout", 32'(GPMC_DATA_OUT), 0);
    chk("rst_oe", 32'(GPMC_DATA_OE), 0);
    chk("rst_wait", 32'(GPMC_WAIT), 0);
    chk("rst_err", 32'(err), 0);
    GPMC_RST = 1'b0;

    // single write
    bus(0, 0, 1, 1, 2'b11, 16'h0012);
    chk("lat_addr", 32'(a_addr), 32'h012);
    chk("lat_ena", 32'(a_ena), 0);
    bus(0, 1, 0, 1, 2'b00, 16'hBEEF);
    chk("wr_ena", 32'(a_ena), 1);
    chk("wr_wr", 32'(a_wr), 32'h3);
    chk("wr_din", 32'(a_din), 32'hBEEF);
    chk("wr_addr", 32'(a_addr), 32'h012);
    chk("wr_oe", 32'(GPMC_DATA_OE), 0);
    bus(0, 1, 1, 1, 2'b11, 16'h0);
    chk("wr_end_ena", 32'(a_ena), 0);
    bus(1, 1, 1, 1, 2'b11, 16'h0);

    // burst read of 4 from 0x100
    bus(0, 0, 1, 1, 2'b11, 16'h0100);
    for (int i = 0; i < 4 + RD_LAT + 1; i++) begin
      if (i < 4) bus(0, 1, 1, 0, 2'b11, 16'h0);
      else       bus(0, 1, 1, 1, 2'b11, 16'h0);
      if (i >= RD_LAT + 1) chk("burst_rd", 32'(GPMC_DATA_OUT), 32'h1100 + 32'(i - (RD_LAT + 1)));
`ifdef GPMC_WAIT_EN
      chk("burst_wait", 32'(GPMC_WAIT), 32'(i < RD_LAT + 1));
`endif
    end
    chk("burst_oe", 32'(GPMC_DATA_OE), 1);
    bus(1, 1, 1, 1, 2'b11, 16'h0);
    chk("burst_oe_off", 32'(GPMC_DATA_OE), 0);

    // byte-lane write at top address, then wrap
    bus(0, 0, 1, 1, 2'b11, 16'(MASK));
    bus(0, 1, 0, 1, 2'b10, 16'h5A5A);
    chk("be_wr", 32'(a_wr), 32'h1);
    chk("be_addr", 32'(a_addr), 32'h7FF);
    bus(0, 1, 0, 1, 2'b00, 16'h1234);
    chk("wrap_addr", 32'(a_addr), 32'h000);
    chk("wrap_wr", 32'(a_wr), 32'h3);
    bus(1, 1, 1, 1, 2'b11, 16'h0);

    // CS abort after 2 of 4 read beats
    bus(0, 0, 1, 1, 2'b11, 16'h0200);
    bus(0, 1, 1, 0, 2'b11, 16'h0);
    bus(0, 1, 1, 0, 2'b11, 16'h0);
    bus(1, 1, 1, 0, 2'b11, 16'h0);
    chk("abort_ena", 32'(a_ena), 0);
    chk("abort_oe", 32'(GPMC_DATA_OE), 0);
    for (int i = 0; i < 4; i++) begin
      bus(1, 1, 1, 1, 2'b11, 16'h0);
      chk("abort_dout", 32'(GPMC_DATA_OUT), 32'h1103);
    end

    // protocol error: WE and OE both low
    bus(0, 0, 1, 1, 2'b11, 16'h0300);
    bus(0, 1, 0, 0, 2'b00, 16'hFFFF);
    chk("err_ena", 32'(a_ena), 0);
    chk("err_set", 32'(err), 1);
    bus(0, 1, 1, 1, 2'b11, 16'h0);
    bus(1, 1, 1, 1, 2'b11, 16'h0);
    chk("err_sticky", 32'(err), 1);
    GPMC_RST = 1'b1;
    bus(1, 1, 1, 1, 2'b11, 16'h0);
    chk("err_clr", 32'(err), 0);
    GPMC_RST = 1'b0;

    // randomized traffic, checked every cycle by the compare process
    for (int n = 0; n < 4000; n++) begin
      logic [15:0] ad;
      bit cs, adv, we, oe;
      GPMC_RST = ($urandom_range(0, 299) == 0);
      cs  = ($urandom_range(0, 19) == 0);
      adv = ($urandom_range(0, 7) != 0);
      r   = $urandom_range(0, 39);
      we  = !(r >= 16 && r < 29) && (r != 29);
      oe  = !(r < 16) && (r != 29);
      ad  = 16'($urandom);
      if (!adv && $urandom_range(0, 3) == 0) ad = 16'(MASK - $urandom_range(0, 3));
      bus(cs, adv, we, oe, 2'($urandom_range(0, 3)), ad);
    end

    GPMC_RST = 1'b0;
    bus(1, 1, 1, 1, 2'b11, 16'h0);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
